// File: rtl/typedefs_pkg.sv
// -----------------------------------------------------------------------------
// typedefs_pkg
// Shared types and default timing constants for the LED playback sequencer.
//   color_t      : 2-bit color code as stored in the sequence memory
//   play_state_t : playback FSM states
//   DEF_*        : default parameter values for the sequencer
//   max3()       : constant helper used to size the on/gap timer
// -----------------------------------------------------------------------------
package typedefs_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        ON    = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } play_state_t;

    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_DATA_WIDTH     = 2;
    localparam int DEF_FAST_ON_CYCLES = 4;
    localparam int DEF_SLOW_ON_CYCLES = 8;
    localparam int DEF_GAP_CYCLES     = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/play_timer.sv
// -----------------------------------------------------------------------------
// play_timer
// Loadable down-counter with a zero flag; times the LED on and gap phases.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : load count with load_value (has priority over dec)
//   load_value  : value to load
//   dec         : decrement by one, saturating at zero
//   zero        : count is zero
// -----------------------------------------------------------------------------
module play_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    // NOTE: count_d gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples the
    // pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/led_playback_sequencer.sv
// -----------------------------------------------------------------------------
// led_playback_sequencer
// Walks the sequence memory from address 0 to length-1; for each item it reads
// the color, lights the matching LED for the latched on-time, then blanks all
// LEDs for GAP_CYCLES.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin playback (honored only in IDLE, not with abort)
//   abort               : return to IDLE on the next edge, no done pulse
//   length              : items to play, clamped to 2^ADDR_WIDTH, sampled on start
//   speed               : 1 = fast, 0 = slow on-time, sampled on start
//   mem_rd, mem_addr    : read strobe and address toward the sequence memory
//   mem_data            : read data, valid the cycle after mem_rd
//   led_*               : one-hot color LEDs (all low outside ON)
//   busy                : state is not IDLE
//   done                : one-cycle pulse on normal completion
// All outputs decode from registered state only.
// -----------------------------------------------------------------------------
module led_playback_sequencer
    import typedefs_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FAST_ON_CYCLES = DEF_FAST_ON_CYCLES,
    parameter int SLOW_ON_CYCLES = DEF_SLOW_ON_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  speed,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  led_red,
    output logic                  led_green,
    output logic                  led_blue,
    output logic                  led_yellow,
    output logic                  busy,
    output logic                  done
);

    localparam int TIMER_W = $clog2(max3(SLOW_ON_CYCLES, FAST_ON_CYCLES, GAP_CYCLES) + 1);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

    play_state_t           state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [TIMER_W-1:0]    on_time_q, on_time_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    color_t                color_q, color_d;

    logic                  timer_load, timer_dec, timer_zero;
    logic [TIMER_W-1:0]    timer_value;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  last_item;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    // Compared at ADDR_WIDTH+1 bits so a full-length sequence ends after the
    // top address instead of wrapping index back to 0.
    assign last_item   = (({1'b0, index_q} + (ADDR_WIDTH + 1)'(1)) == len_q);

    play_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            on_time_q <= '0;
            index_q   <= '0;
            // NOTE: datapath registers are reset along with the FSM so the
            // decoded outputs (mem_addr especially) are 0 straight out of reset.
            color_q   <= RED;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            on_time_q <= on_time_d;
            index_q   <= index_d;
            color_q   <= color_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        on_time_d   = on_time_q;
        index_d     = index_q;
        color_d     = color_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = '0;

        if (abort) begin
            // abort also suppresses a start arriving in the same IDLE cycle.
            if (state_q != IDLE) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d     = len_clamped;
                        on_time_d = speed ? TIMER_W'(FAST_ON_CYCLES) : TIMER_W'(SLOW_ON_CYCLES);
                        index_d   = '0;
                        state_d   = (len_clamped == '0) ? DONE : FETCH;
                    end
                end
                FETCH: state_d = LATCH;
                LATCH: begin
                    color_d     = color_t'(mem_data);
                    timer_load  = 1'b1;
                    timer_value = on_time_q - TIMER_W'(1);
                    state_d     = ON;
                end
                ON: begin
                    if (timer_zero) begin
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(GAP_CYCLES - 1);
                        state_d     = GAP;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                GAP: begin
                    if (timer_zero) begin
                        if (last_item) begin
                            state_d = DONE;
                        end else begin
                            index_d = index_q + ADDR_WIDTH'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs, decoded from registered state only.
    always_comb begin
        mem_rd     = (state_q == FETCH);
        mem_addr   = index_q;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        led_red    = 1'b0;
        led_green  = 1'b0;
        led_blue   = 1'b0;
        led_yellow = 1'b0;
        if (state_q == ON) begin
            unique case (color_q)
                RED:     led_red    = 1'b1;
                GREEN:   led_green  = 1'b1;
                BLUE:    led_blue   = 1'b1;
                YELLOW:  led_yellow = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_playback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_playback_sequencer
// Directed bench: each scenario records a per-cycle trace of the outputs
// (cycle 0 = the cycle in which start is sampled), then a table of
// hand-computed {cycle, expected outputs} records is compared against it.
// LED vectors are written {yellow, blue, green, red}.
// -----------------------------------------------------------------------------
module tb_led_playback_sequencer;

    localparam int MAXC = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, speed;
    logic [5:0] length;
    logic       mem_rd;
    logic [4:0] mem_addr;
    logic [1:0] mem_data;
    logic       led_red, led_green, led_blue, led_yellow;
    logic       busy, done;

    logic [1:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    logic [3:0] leds_tr [0:MAXC];
    logic       rd_tr   [0:MAXC];
    logic [4:0] addr_tr [0:MAXC];
    logic       busy_tr [0:MAXC];
    logic       done_tr [0:MAXC];

    typedef struct {
        string      name;
        int         test;
        int         cyc;
        logic [3:0] leds;
        logic       rd;
        logic [4:0] addr;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    led_playback_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .length     (length),
        .speed      (speed),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .led_red    (led_red),
        .led_green  (led_green),
        .led_blue   (led_blue),
        .led_yellow (led_yellow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void add(input string name, input int test, input int cyc,
                                input logic [3:0] leds, input logic rd, input logic [4:0] addr,
                                input logic b, input logic d);
        vec_t v;
        v.name = name; v.test = test; v.cyc = cyc; v.leds = leds;
        v.rd = rd; v.addr = addr; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    // Runs one playback; inputs for cycle c are changed right after the
    // trace of cycle c is taken. Cycle index -1 disables an injection,
    // abort_c == 0 raises abort together with start.
    task automatic play(input logic [5:0] len, input logic spd, input int ncyc,
                        input int start_c, input int toggle_c, input int abort_c);
        for (int c = 0; c <= MAXC; c++) begin
            leds_tr[c] = '0; rd_tr[c] = 1'b0; addr_tr[c] = '0;
            busy_tr[c] = 1'b0; done_tr[c] = 1'b0;
        end
        @(negedge clk);
        length = len; speed = spd; start = 1'b1; abort = (abort_c == 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            leds_tr[c] = {led_yellow, led_blue, led_green, led_red};
            rd_tr[c]   = mem_rd;
            addr_tr[c] = mem_addr;
            busy_tr[c] = busy;
            done_tr[c] = done;
            if (c == start_c)  start = 1'b1;
            if (c == toggle_c) begin speed = ~speed; length = 6'd1; end
            if (c == abort_c)  abort = 1'b1;
        end
    endtask

    task automatic check_vectors(input int test);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].test == test) begin
                check($sformatf("%s_c%0d_leds", vecs[i].name, vecs[i].cyc), 32'(leds_tr[vecs[i].cyc]), 32'(vecs[i].leds));
                check($sformatf("%s_c%0d_rd",   vecs[i].name, vecs[i].cyc), 32'(rd_tr[vecs[i].cyc]),   32'(vecs[i].rd));
                check($sformatf("%s_c%0d_addr", vecs[i].name, vecs[i].cyc), 32'(addr_tr[vecs[i].cyc]), 32'(vecs[i].addr));
                check($sformatf("%s_c%0d_busy", vecs[i].name, vecs[i].cyc), 32'(busy_tr[vecs[i].cyc]), 32'(vecs[i].busy));
                check($sformatf("%s_c%0d_done", vecs[i].name, vecs[i].cyc), 32'(done_tr[vecs[i].cyc]), 32'(vecs[i].done));
            end
        end
    endtask

    function automatic int count_rd(input int ncyc);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (rd_tr[c]) n++;
        return n;
    endfunction

    function automatic int count_done(input int ncyc);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (done_tr[c]) n++;
        return n;
    endfunction

    function automatic int count_led(input int ncyc, input int bit_idx);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (leds_tr[c][bit_idx]) n++;
        return n;
    endfunction

    task automatic load_short_mem();
        for (int i = 0; i < 32; i++) mem[i] = 2'd0;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    endtask

    initial begin
        int bad;
        int idx;

        // Test 1: {2,0,3,1}, length 4, fast (P = 8)
        add("t1", 1,  1, 4'b0000, 1, 0, 1, 0);
        add("t1", 1,  2, 4'b0000, 0, 0, 1, 0);
        add("t1", 1,  3, 4'b0100, 0, 0, 1, 0);
        add("t1", 1,  6, 4'b0100, 0, 0, 1, 0);
        add("t1", 1,  7, 4'b0000, 0, 0, 1, 0);
        add("t1", 1,  9, 4'b0000, 1, 1, 1, 0);
        add("t1", 1, 11, 4'b0001, 0, 1, 1, 0);
        add("t1", 1, 14, 4'b0001, 0, 1, 1, 0);
        add("t1", 1, 15, 4'b0000, 0, 1, 1, 0);
        add("t1", 1, 17, 4'b0000, 1, 2, 1, 0);
        add("t1", 1, 19, 4'b1000, 0, 2, 1, 0);
        add("t1", 1, 22, 4'b1000, 0, 2, 1, 0);
        add("t1", 1, 23, 4'b0000, 0, 2, 1, 0);
        add("t1", 1, 25, 4'b0000, 1, 3, 1, 0);
        add("t1", 1, 27, 4'b0010, 0, 3, 1, 0);
        add("t1", 1, 30, 4'b0010, 0, 3, 1, 0);
        add("t1", 1, 32, 4'b0000, 0, 3, 1, 0);
        add("t1", 1, 33, 4'b0000, 0, 3, 1, 1);
        add("t1", 1, 34, 4'b0000, 0, 3, 0, 0);
        // Test 2: same memory, length 2, slow (P = 12)
        add("t2", 2,  1, 4'b0000, 1, 0, 1, 0);
        add("t2", 2,  3, 4'b0100, 0, 0, 1, 0);
        add("t2", 2, 10, 4'b0100, 0, 0, 1, 0);
        add("t2", 2, 11, 4'b0000, 0, 0, 1, 0);
        add("t2", 2, 13, 4'b0000, 1, 1, 1, 0);
        add("t2", 2, 15, 4'b0001, 0, 1, 1, 0);
        add("t2", 2, 22, 4'b0001, 0, 1, 1, 0);
        add("t2", 2, 24, 4'b0000, 0, 1, 1, 0);
        add("t2", 2, 25, 4'b0000, 0, 1, 1, 1);
        add("t2", 2, 26, 4'b0000, 0, 1, 0, 0);
        // Test 3: length 0
        add("t3", 3,  1, 4'b0000, 0, 0, 1, 1);
        add("t3", 3,  2, 4'b0000, 0, 0, 0, 0);
        // Test 4: length 32 on memory i%4, fast
        add("t4", 4,   1, 4'b0000, 1,  0, 1, 0);
        add("t4", 4,   3, 4'b0001, 0,  0, 1, 0);
        add("t4", 4,  11, 4'b0010, 0,  1, 1, 0);
        add("t4", 4, 249, 4'b0000, 1, 31, 1, 0);
        add("t4", 4, 251, 4'b1000, 0, 31, 1, 0);
        add("t4", 4, 256, 4'b0000, 0, 31, 1, 0);
        add("t4", 4, 257, 4'b0000, 0, 31, 1, 1);
        add("t4", 4, 258, 4'b0000, 0, 31, 0, 0);
        // Test 5: length 63 clamps to 32
        add("t5", 5, 249, 4'b0000, 1, 31, 1, 0);
        add("t5", 5, 257, 4'b0000, 0, 31, 1, 1);
        add("t5", 5, 258, 4'b0000, 0, 31, 0, 0);
        // Test 6: start + speed/length change in item 2, abort in ON at cycle 20
        add("t6", 6, 17, 4'b0000, 1, 2, 1, 0);
        add("t6", 6, 19, 4'b1000, 0, 2, 1, 0);
        add("t6", 6, 20, 4'b1000, 0, 2, 1, 0);
        add("t6", 6, 21, 4'b0000, 0, 2, 0, 0);
        add("t6", 6, 25, 4'b0000, 0, 2, 0, 0);
        // Test 7: abort together with start in IDLE
        add("t7", 7,  1, 4'b0000, 0, 2, 0, 0);
        add("t7", 7,  3, 4'b0000, 0, 2, 0, 0);
        // Test 8: replay after reset
        add("t8", 8,  1, 4'b0000, 1, 0, 1, 0);
        add("t8", 8,  3, 4'b0100, 0, 0, 1, 0);

        rst = 1'b1; start = 1'b0; abort = 1'b0; speed = 1'b0; length = '0;
        load_short_mem();
        #1;
        check("reset_outputs", 32'({mem_rd, mem_addr, led_yellow, led_blue, led_green, led_red, busy, done}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        play(6'd4, 1'b1, 40, -1, -1, -1);
        check_vectors(1);
        check("t1_rd_count", 32'(count_rd(40)), 32'd4);
        check("t1_done_count", 32'(count_done(40)), 32'd1);
        for (int b = 0; b < 4; b++) check($sformatf("t1_led%0d_cycles", b), 32'(count_led(40, b)), 32'd4);

        play(6'd2, 1'b0, 30, -1, -1, -1);
        check_vectors(2);
        check("t2_rd_count", 32'(count_rd(30)), 32'd2);

        play(6'd0, 1'b1, 4, -1, -1, -1);
        check_vectors(3);
        check("t3_rd_count", 32'(count_rd(4)), 32'd0);

        for (int i = 0; i < 32; i++) mem[i] = 2'(i % 4);
        play(6'd32, 1'b1, 260, -1, -1, -1);
        check_vectors(4);
        check("t4_rd_count", 32'(count_rd(260)), 32'd32);
        bad = 0; idx = 0;
        for (int c = 1; c <= 260; c++) begin
            if (rd_tr[c]) begin
                if (32'(addr_tr[c]) != 32'(idx)) bad++;
                idx++;
            end
        end
        check("t4_addr_seq_errors", 32'(bad), 32'd0);

        play(6'd63, 1'b1, 260, -1, -1, -1);
        check_vectors(5);
        check("t5_rd_count", 32'(count_rd(260)), 32'd32);

        load_short_mem();
        play(6'd4, 1'b1, 30, 18, 18, 20);
        check_vectors(6);
        check("t6_done_count", 32'(count_done(30)), 32'd0);

        play(6'd4, 1'b1, 3, -1, -1, 0);
        check_vectors(7);
        check("t7_rd_count", 32'(count_rd(3)), 32'd0);

        // Reset during item 1's gap (cycles 15-16, mem_addr = 1).
        play(6'd4, 1'b1, 15, -1, -1, -1);
        check("rst_pre_gap_state", 32'({busy, mem_addr, leds_tr[15]}), 32'({1'b1, 5'd1, 4'b0000}));
        #1 rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({mem_rd, mem_addr, led_yellow, led_blue, led_green, led_red, busy, done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        play(6'd4, 1'b1, 5, -1, -1, -1);
        check_vectors(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
